// File: rtl/pwm_multi.sv
// Multi-channel PWM with double-buffered on/off tick counts and a per-channel run FSM.
// Optional macro PWM_POLARITY_EN adds a per-channel output inversion register.
module pwm_multi #(
  parameter int                    CHANNELS   = 4,
  parameter int                    CNT_WIDTH  = 16,
  parameter int                    ADDR_WIDTH = 6,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = 6'h18
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [CNT_WIDTH-1:0]  wr_data,
  output logic [CHANNELS-1:0]   pwm_out,
  output logic [CHANNELS-1:0]   period_done
);

`ifdef PWM_POLARITY_EN
  localparam int LAST_OFF = 2 * CHANNELS + 1;
`else
  localparam int LAST_OFF = 2 * CHANNELS;
`endif

  typedef enum logic [1:0] {S_IDLE, S_ON, S_OFF, S_HOLD} state_t;

  logic [ADDR_WIDTH:0]  off_full;
  logic                 hit;
  logic [CHANNELS-1:0]  enable;
  logic [CHANNELS-1:0]  enable_n;
  logic [CNT_WIDTH-1:0] on_s   [CHANNELS];
  logic [CNT_WIDTH-1:0] off_s  [CHANNELS];
  logic [CNT_WIDTH-1:0] on_sn  [CHANNELS];
  logic [CNT_WIDTH-1:0] off_sn [CHANNELS];
  logic [CNT_WIDTH-1:0] on_a   [CHANNELS];
  logic [CNT_WIDTH-1:0] off_a  [CHANNELS];
  logic [CNT_WIDTH-1:0] on_an  [CHANNELS];
  logic [CNT_WIDTH-1:0] off_an [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt    [CHANNELS];
  logic [CNT_WIDTH-1:0] cnt_n  [CHANNELS];
  state_t               st     [CHANNELS];
  state_t               st_n   [CHANNELS];
  logic [CHANNELS-1:0]  reload;
  logic [CHANNELS-1:0]  lvl_n;
  logic [CHANNELS-1:0]  pd_n;
  logic [CHANNELS-1:0]  out_n;
  logic [CHANNELS-1:0]  pwm_q;
  logic [CHANNELS-1:0]  pd_q;
`ifdef PWM_POLARITY_EN
  logic [CHANNELS-1:0]  pol;
  logic [CHANNELS-1:0]  pol_n;
`endif

  // The subtraction is one bit wider so addresses below the base wrap far out of range.
  assign off_full = {1'b0, wr_addr} - {1'b0, BASE_ADDR};
  assign hit      = wr_en && (wr_addr >= BASE_ADDR) &&
                    (off_full <= (ADDR_WIDTH+1)'(LAST_OFF));

  always_comb begin : decode
    enable_n = enable;
    if (hit && off_full == '0)
      enable_n = wr_data[CHANNELS-1:0];
    for (int k = 0; k < CHANNELS; k++) begin
      on_sn[k]  = (hit && off_full == (ADDR_WIDTH+1)'(2*k+1)) ? wr_data : on_s[k];
      off_sn[k] = (hit && off_full == (ADDR_WIDTH+1)'(2*k+2)) ? wr_data : off_s[k];
    end
`ifdef PWM_POLARITY_EN
    pol_n = pol;
    if (hit && off_full == (ADDR_WIDTH+1)'(LAST_OFF))
      pol_n = wr_data[CHANNELS-1:0];
`endif
  end

  // Next-shadow values feed the reload so a write landing on a boundary is not lost.
  always_comb begin : fsm_next
    reload = '0;
    lvl_n  = '0;
    pd_n   = '0;
    out_n  = '0;
    for (int k = 0; k < CHANNELS; k++) begin
      st_n[k]   = st[k];
      cnt_n[k]  = cnt[k];
      on_an[k]  = on_a[k];
      off_an[k] = off_a[k];
      if (!enable_n[k]) begin
        st_n[k]  = S_IDLE;
        cnt_n[k] = '0;
      end else begin
        case (st[k])
          S_IDLE, S_HOLD: reload[k] = 1'b1;
          S_ON: begin
            if (cnt[k] == on_a[k] - CNT_WIDTH'(1)) begin
              if (off_a[k] == '0) begin
                reload[k] = 1'b1;
              end else begin
                st_n[k]  = S_OFF;
                cnt_n[k] = '0;
              end
            end else begin
              cnt_n[k] = cnt[k] + CNT_WIDTH'(1);
            end
          end
          S_OFF: begin
            if (cnt[k] == off_a[k] - CNT_WIDTH'(1))
              reload[k] = 1'b1;
            else
              cnt_n[k] = cnt[k] + CNT_WIDTH'(1);
          end
          default: begin
            st_n[k]  = S_IDLE;
            cnt_n[k] = '0;
          end
        endcase
      end
      if (reload[k]) begin
        on_an[k]  = on_sn[k];
        off_an[k] = off_sn[k];
        cnt_n[k]  = '0;
        if (on_sn[k] != '0)
          st_n[k] = S_ON;
        else if (off_sn[k] != '0)
          st_n[k] = S_OFF;
        else
          st_n[k] = S_HOLD;
      end
      lvl_n[k] = (st_n[k] == S_ON);
      pd_n[k]  = ((st_n[k] == S_OFF) && (cnt_n[k] == off_an[k] - CNT_WIDTH'(1))) ||
                 ((st_n[k] == S_ON) && (off_an[k] == '0) &&
                  (cnt_n[k] == on_an[k] - CNT_WIDTH'(1)));
    end
`ifdef PWM_POLARITY_EN
    out_n = lvl_n ^ pol_n;
`else
    out_n = lvl_n;
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      enable <= '0;
      pwm_q  <= '0;
      pd_q   <= '0;
`ifdef PWM_POLARITY_EN
      pol    <= '0;
`endif
      for (int k = 0; k < CHANNELS; k++) begin
        on_s[k]  <= '0;
        off_s[k] <= '0;
        on_a[k]  <= '0;
        off_a[k] <= '0;
        cnt[k]   <= '0;
        st[k]    <= S_IDLE;
      end
    end else begin
      enable <= enable_n;
      pwm_q  <= out_n;
      pd_q   <= pd_n;
`ifdef PWM_POLARITY_EN
      pol    <= pol_n;
`endif
      for (int k = 0; k < CHANNELS; k++) begin
        on_s[k]  <= on_sn[k];
        off_s[k] <= off_sn[k];
        on_a[k]  <= on_an[k];
        off_a[k] <= off_an[k];
        cnt[k]   <= cnt_n[k];
        st[k]    <= st_n[k];
      end
    end
  end

  assign pwm_out     = pwm_q;
  assign period_done = pd_q;

endmodule

// File: tb/tb_pwm_multi.sv
// Self-checking bench for pwm_multi: table-driven per-cycle vectors through a scoreboard queue,
// plus hand-written sequences for reload, disable, reset and polarity corner cases.
module tb_pwm_multi;
  localparam int CH = 4;
  localparam int CW = 16;
  localparam int AW = 6;

  localparam logic [AW-1:0] A_BELOW = 6'h17;
  localparam logic [AW-1:0] A_EN    = 6'h18;
  localparam logic [AW-1:0] A_ON0   = 6'h19;
  localparam logic [AW-1:0] A_OFF0  = 6'h1A;
  localparam logic [AW-1:0] A_ON1   = 6'h1B;
  localparam logic [AW-1:0] A_OFF1  = 6'h1C;
  localparam logic [AW-1:0] A_ON2   = 6'h1D;
  localparam logic [AW-1:0] A_OFF2  = 6'h1E;
`ifdef PWM_POLARITY_EN
  localparam logic [AW-1:0] A_POL   = 6'h21;
  localparam logic [AW-1:0] A_PAST  = 6'h22;
`else
  localparam logic [AW-1:0] A_PAST  = 6'h21;
`endif

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          wr_en = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [CW-1:0] wr_data = '0;
  logic [CH-1:0] pwm_out;
  logic [CH-1:0] period_done;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [CW-1:0] data;
    logic [CH-1:0] pwm;
    logic [CH-1:0] pd;
  } vec_t;

  typedef struct {
    logic [CH-1:0] pwm;
    logic [CH-1:0] pd;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];

  pwm_multi dut (
    .clock       (clock),
    .reset       (reset),
    .wr_en       (wr_en),
    .wr_addr     (wr_addr),
    .wr_data     (wr_data),
    .pwm_out     (pwm_out),
    .period_done (period_done)
  );

  always #5 clock = ~clock;

  task automatic check(input logic [CH-1:0] epwm, input logic [CH-1:0] epd, input string name);
    vectors++;
    if (pwm_out !== epwm || period_done !== epd) begin
      miscompares++;
      $display("FAIL %s: got pwm_out=%b period_done=%b, want pwm_out=%b period_done=%b",
               name, pwm_out, period_done, epwm, epd);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, then compare after the next rising edge.
  task automatic step(input logic we, input logic [AW-1:0] addr, input logic [CW-1:0] data,
                      input logic [CH-1:0] epwm, input logic [CH-1:0] epd, input string name);
    exp_t e;
    wr_en   = we;
    wr_addr = addr;
    wr_data = data;
    e.pwm = epwm;
    e.pd  = epd;
    sb.push_back(e);
    @(negedge clock);
    wr_en = 1'b0;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check(e.pwm, e.pd, name);
    end
  endtask

  task automatic idle(input logic [CH-1:0] epwm, input logic [CH-1:0] epd, input string name);
    step(1'b0, '0, '0, epwm, epd, name);
  endtask

  task automatic tv(input logic we, input logic [AW-1:0] addr, input logic [CW-1:0] data,
                    input logic [CH-1:0] epwm, input logic [CH-1:0] epd);
    vec_t v;
    v.we = we; v.addr = addr; v.data = data; v.pwm = epwm; v.pd = epd;
    tbl.push_back(v);
  endtask

  task automatic run_table(input string tag);
    foreach (tbl[i])
      step(tbl[i].we, tbl[i].addr, tbl[i].data, tbl[i].pwm, tbl[i].pd,
           $sformatf("%s_%0d", tag, i));
    tbl.delete();
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check('0, '0, "reset_state");
    reset = 1'b1;

    // Channel 0 at 3 on / 2 off: 1,1,1,0,0 with the pulse on the last off tick.
    tv(1'b1, A_ON0,  16'd3, 4'b0000, 4'b0000);
    tv(1'b1, A_OFF0, 16'd2, 4'b0000, 4'b0000);
    for (int i = 0; i < 10; i++)
      tv(i == 0, A_EN, 16'd1, ((i % 5) < 3) ? 4'b0001 : 4'b0000,
         ((i % 5) == 4) ? 4'b0001 : 4'b0000);
    run_table("ch0_3_2");

    // Shadow write mid-ON: current period finishes as 3/2, then 1/2 periods.
    idle(4'b0001, 4'b0000, "upd_on0");
    step(1'b1, A_ON0, 16'd1, 4'b0001, 4'b0000, "upd_on1");
    idle(4'b0001, 4'b0000, "upd_on2");
    idle(4'b0000, 4'b0000, "upd_off0");
    idle(4'b0000, 4'b0001, "upd_off1");
    idle(4'b0001, 4'b0000, "short_on");
    idle(4'b0000, 4'b0000, "short_off0");
    idle(4'b0000, 4'b0001, "short_off1");

    // Write lands on the boundary edge: the reload takes the new value.
    step(1'b1, A_ON0, 16'd3, 4'b0001, 4'b0000, "coll_on0");
    idle(4'b0001, 4'b0000, "coll_on1");
    idle(4'b0001, 4'b0000, "coll_on2");
    idle(4'b0000, 4'b0000, "coll_off0");
    idle(4'b0000, 4'b0001, "coll_off1");

    // Disable during ON, then re-enable restarts with a full ON phase.
    idle(4'b0001, 4'b0000, "dis_on0");
    idle(4'b0001, 4'b0000, "dis_on1");
    step(1'b1, A_EN, 16'd0, 4'b0000, 4'b0000, "dis_now");
    idle(4'b0000, 4'b0000, "dis_idle0");
    idle(4'b0000, 4'b0000, "dis_idle1");
    step(1'b1, A_EN, 16'd1, 4'b0001, 4'b0000, "reen_on0");
    idle(4'b0001, 4'b0000, "reen_on1");
    idle(4'b0001, 4'b0000, "reen_on2");
    idle(4'b0000, 4'b0000, "reen_off0");
    idle(4'b0000, 4'b0001, "reen_off1");

    // Ch1 0/4 (always low), ch2 5/0 (always high), started together.
    tv(1'b1, A_EN,   16'd0, 4'b0000, 4'b0000);
    tv(1'b1, A_ON1,  16'd0, 4'b0000, 4'b0000);
    tv(1'b1, A_OFF1, 16'd4, 4'b0000, 4'b0000);
    tv(1'b1, A_ON2,  16'd5, 4'b0000, 4'b0000);
    tv(1'b1, A_OFF2, 16'd0, 4'b0000, 4'b0000);
    for (int k = 0; k < 12; k++)
      tv(k == 0, A_EN, 16'd6, 4'b0100,
         (((k % 4) == 3) ? 4'b0010 : 4'b0000) | (((k % 5) == 4) ? 4'b0100 : 4'b0000));
    run_table("ch12");

    // Asynchronous reset mid-period.
    #2;
    reset = 1'b0;
    #1;
    check('0, '0, "async_reset");
    @(negedge clock);
    reset = 1'b1;

    step(1'b1, A_ON0,   16'd2,      4'b0000, 4'b0000, "post_on0");
    step(1'b1, A_OFF0,  16'd2,      4'b0000, 4'b0000, "post_off0");
    step(1'b1, A_BELOW, 16'h000F,   4'b0000, 4'b0000, "wr_below");
    step(1'b1, A_PAST,  16'h000F,   4'b0000, 4'b0000, "wr_past");
    idle(4'b0000, 4'b0000, "still_idle0");
    idle(4'b0000, 4'b0000, "still_idle1");
    step(1'b1, A_EN, 16'd1, 4'b0001, 4'b0000, "post_en_on0");
    idle(4'b0001, 4'b0000, "post_en_on1");
    idle(4'b0000, 4'b0000, "post_en_off0");
    idle(4'b0000, 4'b0001, "post_en_off1");

`ifdef PWM_POLARITY_EN
    step(1'b1, A_EN,   16'd0, 4'b0000, 4'b0000, "pol_dis");
    step(1'b1, A_POL,  16'd1, 4'b0001, 4'b0000, "pol_idle");
    step(1'b1, A_ON0,  16'd3, 4'b0001, 4'b0000, "pol_on_wr");
    step(1'b1, A_OFF0, 16'd2, 4'b0001, 4'b0000, "pol_off_wr");
    step(1'b1, A_EN,   16'd1, 4'b0000, 4'b0000, "pol_run0");
    idle(4'b0000, 4'b0000, "pol_run1");
    idle(4'b0000, 4'b0000, "pol_run2");
    idle(4'b0001, 4'b0000, "pol_run3");
    idle(4'b0001, 4'b0001, "pol_run4");
    step(1'b1, A_EN,   16'd0, 4'b0001, 4'b0000, "pol_off_idle");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- Multi-channel successor to the single-channel AUX PWM.
- CHANNELS independent PWM generators, each with its own on/off tick counts.
- Registers are written from the memory-controller write strobe, already synchronised into the clock domain.
- Period values are double-buffered, so an update never produces a glitched period.
- Outputs feed the iobuf data-out inputs of the Bus Pirate IO pins.

Parameters:
- CHANNELS, 4: number of PWM channels (1..8).
- CNT_WIDTH, 16: width of the on/off period registers and counters.
- ADDR_WIDTH, 6: register address width.
- BASE_ADDR, 6'h18: address of the first register.

Ports:
- clock  in  1: system clock.
- reset  in  1: asynchronous, active-low reset.
- wr_en  in  1: single-cycle write strobe, synchronous to clock.
- wr_addr  in  ADDR_WIDTH: register address.
- wr_data  in  CNT_WIDTH: write data.
- pwm_out  out  CHANNELS: registered PWM outputs.
- period_done  out  CHANNELS: one-cycle pulse on the last tick of each period.

Behaviour:
- Register map, with off = wr_addr - BASE_ADDR:
  - off 0: ENABLE, bits [CHANNELS-1:0]; upper bits ignored.
  - off 1+2k: ON_k shadow.
  - off 2+2k: OFF_k shadow.
  - Addresses below BASE_ADDR or beyond the last register: write ignored, no side effect.
- Reset (reset=0, asynchronous): all shadows, active copies, counters and ENABLE = 0; all channels in IDLE; pwm_out=0; period_done=0.
- Shadow writes take effect on the clock edge of wr_en.
- Active copies (on_a, off_a) load from the shadows only:
  - on the IDLE->run transition, and
  - at the period boundary (last OFF tick).
- If a write and a reload hit the same channel in the same cycle, the active copy takes the new wr_data.
- Per-channel FSM:
  - IDLE: pwm_out=0, counter=0. When ENABLE[k]=1, load active copies, then:
    - both on_a and off_a 0: go to HOLD.
    - on_a>0: go to ON; pwm_out=1 from the next cycle.
    - on_a=0: go to OFF.
  - ON: pwm_out=1 for exactly on_a cycles. On the last tick, counter clears and the FSM goes to OFF; if off_a=0 it treats that tick as the boundary instead (reload, pulse period_done, stay in ON).
  - OFF: pwm_out=0 for exactly off_a cycles. Last tick is the boundary: reload active copies, pulse period_done[k], clear counter, then go to ON if the new on_a>0, else OFF. If both new values are 0, go to HOLD.
  - HOLD: pwm_out=0, no period_done. Re-samples the shadows every cycle and leaves HOLD, by the IDLE rules, as soon as either is nonzero.
- Resulting timing:
  - Period = on_a + off_a cycles, with no dead cycle between periods.
  - on_a=0: output constantly low, period_done every off_a cycles.
  - off_a=0: output constantly high, period_done every on_a cycles.
- ENABLE[k] cleared in any state: next cycle IDLE, pwm_out[k]=0, counter cleared, no period_done.
- Re-enabling always starts a fresh period with the ON phase.
- Counters are CNT_WIDTH wide. They compare against active value - 1 and never wrap; maximum phase length is 2^CNT_WIDTH - 1.
- Channels are fully independent. A single ENABLE write starts several channels on the same cycle, phase-aligned.

Optional Feature:
- Macro: PWM_POLARITY_EN.
- Defined:
  - Adds a POLARITY register at off 1+2*CHANNELS, bits [CHANNELS-1:0], reset 0.
  - pwm_out[k] = FSM level XOR POLARITY[k] in all states, including IDLE and HOLD; an inverted idle channel drives 1.
  - POLARITY changes apply on the next clock, not deferred to the boundary.
- Undefined: the address is out of range (write ignored) and outputs are never inverted.

Test Plan:
- ON_0=3, OFF_0=2, ENABLE=1 -> pwm_out[0] = 1,1,1,0,0 repeating; period_done[0] high on every 5th cycle (last OFF tick).
- Running 3/2, write ON_0=1 mid-ON -> current period completes as 3/2; next period is 1,0,0; no short or long period.
- ON_1=0, OFF_1=4, enable ch1 -> pwm_out[1] constant 0, period_done[1] every 4 cycles. ON_2=5, OFF_2=0 -> constant 1, pulse every 5 cycles.
- ENABLE cleared during ON -> pwm_out=0 next cycle, no pulse. Re-enable -> ON phase restarts with full on count.
- Reset asserted mid-period -> outputs 0 immediately (asynchronous). After release, writes to BASE_ADDR-1 and past the map change nothing; channel stays idle.
- PWM_POLARITY_EN: POLARITY=1, 3/2 on ch0 -> 0,0,0,1,1; ch0 disabled -> pwm_out[0]=1.
